// File: rtl/bcd_disp_pkg.sv
// Shared types and segment patterns for the BCD seven-segment scanner.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package bcd_disp_pkg;

  localparam int N_DIGITS = 5;

  typedef logic [2:0] dig_idx_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_of(
    input logic [3:0] bcd
  );
    logic [6:0] s;
    case (bcd)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to seven-segment decoder.
// Codes 10..15 show a dash; blank_i forces all segments off.
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  input  logic       act_low_i,
  output logic [6:0] seg_o
);

  logic [6:0] seg_hi;

  always_comb begin
    seg_hi = blank_i ? SEG_BLANK : seg_of(bcd_i);
    seg_o  = act_low_i ? ~seg_hi : seg_hi;
  end

endmodule

// File: rtl/bcd_7seg_scan.sv
// 5-digit multiplexed seven-segment scanner with per-frame snapshot.
// Optional LEADING_ZERO_BLANK_EN blanks leading zeros above the units.
module bcd_7seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int DIV          = 10000,
  parameter int BLANK_CYC    = 4,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [3:0] uni_i,
  input  logic [3:0] dec_i,
  input  logic [3:0] cen_i,
  input  logic [3:0] mil_i,
  input  logic [3:0] mil10_i,
  output logic [6:0] seg_o,
  output logic [4:0] an_o,
  output logic       frame_o
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PSC_MAX = PW'(DIV - 1);
  localparam logic [PW-1:0] BLK_END = PW'(BLANK_CYC);
  localparam logic POL = COMMON_ANODE;
  localparam logic [6:0] SEG_OFF = POL ? 7'h7F : 7'h00;
  localparam logic [4:0] AN_OFF = POL ? 5'h1F : 5'h00;
  localparam dig_idx_t IDX_LAST = dig_idx_t'(N_DIGITS - 1);

  logic [PW-1:0] psc_q, psc_d;
  dig_idx_t idx_q, idx_d;
  logic [N_DIGITS-1:0][3:0] snap_q, snap_d;
  logic [6:0] seg_q, seg_d;
  logic [4:0] an_q, an_d;
  logic [4:0] an_hot;
  logic tick, frame;
  logic [3:0] cur;
  logic cur_blank;
  logic [N_DIGITS-1:0] lz;

  assign tick  = (psc_q == PSC_MAX);
  assign frame = tick && (idx_q == IDX_LAST);

  always_comb begin
    psc_d  = tick ? '0 : psc_q + 1'b1;
    idx_d  = idx_q;
    snap_d = snap_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    if (frame) begin
      snap_d = {mil10_i, mil_i, cen_i, dec_i, uni_i};
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank only while every digit above it is also zero.
  always_comb begin
    lz = '0;
    lz[N_DIGITS-1] = (snap_q[N_DIGITS-1] == 4'd0);
    for (int i = N_DIGITS - 2; i >= 1; i--) begin
      lz[i] = lz[i+1] && (snap_q[i] == 4'd0);
    end
  end
`else
  assign lz = '0;
`endif

  always_comb begin
    cur       = snap_q[0];
    cur_blank = lz[0];
    case (idx_q)
      3'd1: begin
        cur       = snap_q[1];
        cur_blank = lz[1];
      end
      3'd2: begin
        cur       = snap_q[2];
        cur_blank = lz[2];
      end
      3'd3: begin
        cur       = snap_q[3];
        cur_blank = lz[3];
      end
      3'd4: begin
        cur       = snap_q[4];
        cur_blank = lz[4];
      end
      default: ;
    endcase
  end

  seg7_decode u_dec (
    .bcd_i     (cur),
    .blank_i   (cur_blank),
    .act_low_i (POL),
    .seg_o     (seg_d)
  );

  always_comb begin
    an_hot = 5'd1 << idx_q;
    if (psc_q < BLK_END) begin
      an_d = AN_OFF;
    end else begin
      an_d = POL ? ~an_hot : an_hot;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      psc_q  <= '0;
      idx_q  <= '0;
      snap_q <= '0;
      seg_q  <= SEG_OFF;
      an_q   <= AN_OFF;
    end else begin
      psc_q  <= psc_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign seg_o   = seg_q;
  assign an_o    = an_q;
  assign frame_o = frame;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Bench for bcd_7seg_scan: table of digit vectors, queued expectations,
// common-anode and common-cathode instances run side by side.
module tb_bcd_7seg_scan;

  localparam int DIV = 8;
  localparam int BLK = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] uni, dec, cen, mil, mil10;
  logic [6:0] seg1, seg0;
  logic [4:0] an1, an0;
  logic fr1, fr0;

  always #5 clk = ~clk;

  bcd_7seg_scan #(.DIV(DIV), .BLANK_CYC(BLK), .COMMON_ANODE(1'b1)) u_ca (
    .clk_i(clk), .rst_n_i(rst_n),
    .uni_i(uni), .dec_i(dec), .cen_i(cen),
    .mil_i(mil), .mil10_i(mil10),
    .seg_o(seg1), .an_o(an1), .frame_o(fr1)
  );

  bcd_7seg_scan #(.DIV(DIV), .BLANK_CYC(BLK), .COMMON_ANODE(1'b0)) u_cc (
    .clk_i(clk), .rst_n_i(rst_n),
    .uni_i(uni), .dec_i(dec), .cen_i(cen),
    .mil_i(mil), .mil10_i(mil10),
    .seg_o(seg0), .an_o(an0), .frame_o(fr0)
  );

  typedef struct packed {
    logic [4:0][3:0] d;
    logic [4:0][6:0] pat;
  } vec_t;

  typedef struct packed {
    logic [4:0] an;
    logic [6:0] seg;
    logic       fr;
  } exp_t;

  exp_t q[$];
  vec_t vt[8];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [11:0] act,
                     input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0][3:0] d);
    uni = d[0];
    dec = d[1];
    cen = d[2];
    mil = d[3];
    mil10 = d[4];
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (fr1) seen = 1'b1;
    end
    chk("frame_seen", {11'd0, seen}, 12'd1);
  endtask

  // Called at the negedge one cycle after frame_o; covers one full frame
  // and ends just after the next frame tick, so calls can be chained.
  task automatic check_frame(input logic [4:0][6:0] pat, input int chg_at,
                             input logic [4:0][3:0] nd);
    exp_t e;
    logic [4:0] oh;
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < DIV; c++) begin
        oh = 5'd1 << s;
        e.an = (c < BLK) ? 5'h1F : ~oh;
        e.seg = ~pat[s];
        e.fr = (s == 4) && (c == DIV - 2);
        q.push_back(e);
      end
    end
    for (int i = 0; i < 5 * DIV; i++) begin
      @(negedge clk);
      e = q.pop_front();
      chk("an", {7'd0, an1}, {7'd0, e.an});
      chk("seg", {5'd0, seg1}, {5'd0, e.seg});
      chk("frame", {11'd0, fr1}, {11'd0, e.fr});
      chk("cc_an", {7'd0, an0}, {7'd0, ~e.an});
      chk("cc_seg", {5'd0, seg0}, {5'd0, ~e.seg});
      if (i == chg_at) drive(nd);
    end
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_seg"}, {5'd0, seg1}, 12'h07F);
    chk({tag, "_an"}, {7'd0, an1}, 12'h01F);
    chk({tag, "_fr"}, {11'd0, fr1}, 12'd0);
    chk({tag, "_cc_seg"}, {5'd0, seg0}, 12'h000);
    chk({tag, "_cc_an"}, {7'd0, an0}, 12'h000);
  endtask

  // Released at a negedge; first frame shows the zero snapshot and
  // frame_o first fires in cycle 5*DIV-1.
  task automatic release_check();
    rst_n = 1'b1;
    for (int n = 1; n < 5 * DIV; n++) begin
      @(negedge clk);
      chk("first_frame", {11'd0, fr1}, {11'd0, (n == 5 * DIV - 1)});
      if (n == 5) begin
        chk("zero_an", {7'd0, an1}, 12'h01E);
        chk("zero_seg", {5'd0, seg1}, {5'd0, ~7'h3F});
      end
    end
  endtask

  initial begin
    vt[0] = '{d: {4'd1, 4'd0, 4'd8, 4'd7, 4'd4},
              pat: {7'h06, 7'h3F, 7'h7F, 7'h07, 7'h66}};
    vt[1] = '{d: {4'd1, 4'd2, 4'd3, 4'd4, 4'd5},
              pat: {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D}};
    vt[2] = '{d: {4'd6, 4'd5, 4'd5, 4'd3, 4'd5},
              pat: {7'h7D, 7'h6D, 7'h6D, 7'h4F, 7'h6D}};
    vt[3] = '{d: {4'd7, 4'd0, 4'd9, 4'd2, 4'hC},
              pat: {7'h07, 7'h3F, 7'h6F, 7'h5B, 7'h40}};
`ifdef LEADING_ZERO_BLANK_EN
    vt[4] = '{d: {4'd0, 4'd0, 4'd0, 4'd4, 4'd2},
              pat: {7'h00, 7'h00, 7'h00, 7'h66, 7'h5B}};
    vt[5] = '{d: {4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
              pat: {7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}};
`else
    vt[4] = '{d: {4'd0, 4'd0, 4'd0, 4'd4, 4'd2},
              pat: {7'h3F, 7'h3F, 7'h3F, 7'h66, 7'h5B}};
    vt[5] = '{d: {4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
              pat: {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}};
`endif
    vt[6] = '{d: {4'd1, 4'd0, 4'd0, 4'd0, 4'd2},
              pat: {7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h5B}};
    vt[7] = '{d: {4'hF, 4'hA, 4'd8, 4'hB, 4'd9},
              pat: {7'h40, 7'h40, 7'h7F, 7'h40, 7'h6F}};

    rst_n = 1'b0;
    drive({4'd9, 4'd9, 4'd9, 4'd9, 4'd9});
    repeat (3) @(negedge clk);
    chk_off("reset");
    release_check();

    foreach (vt[v]) begin
      drive(vt[v].d);
      wait_frame();
      @(negedge clk);
      check_frame(vt[v].pat, -1, '0);
    end

    // Inputs change mid-frame; the display must hold the old snapshot.
    drive(vt[1].d);
    wait_frame();
    @(negedge clk);
    check_frame(vt[1].pat, 10, vt[2].d);
    check_frame(vt[2].pat, -1, '0);

    // Asynchronous reset while an anode is lit.
    begin
      bit lit;
      lit = 1'b0;
      for (int k = 0; k < 20 && !lit; k++) begin
        @(negedge clk);
        if (an1 != 5'h1F) lit = 1'b1;
      end
      chk("lit_seen", {11'd0, lit}, 12'd1);
    end
    #2 rst_n = 1'b0;
    #1 chk_off("async_rst");
    drive({4'd3, 4'd3, 4'd3, 4'd3, 4'd3});
    repeat (2) @(negedge clk);
    chk_off("rst_hold");
    release_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
